// File: rtl/pipe_accum_pkg.sv
// Shared definitions for the pipelined frame accumulator: default sizing
// and the accumulator FSM state encoding.
package pipe_accum_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_RES_W     = 16;
    localparam int DEF_STAGES    = 2;
    localparam int DEF_ACC_BEATS = 4;
    localparam int DEF_CNT_W     = $clog2(DEF_ACC_BEATS + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } acc_state_e;

endpackage

// File: rtl/pipe_accum_if.sv
// Beat input and frame-result output bundle of pipe_accum.
// The slave modport is the accumulator side.
interface pipe_accum_if
    import pipe_accum_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int RES_W  = DEF_RES_W,
    parameter int CNT_W  = DEF_CNT_W
);

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [RES_W-1:0]  result;
    logic [CNT_W-1:0]  result_count;
    logic              result_sat;
    logic              result_valid;
    logic              result_ready;

    modport master (
        output in_data, in_valid, in_last, result_ready,
        input  in_ready, result, result_count, result_sat, result_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, result_ready,
        output in_ready, result, result_count, result_sat, result_valid
    );

endinterface

// File: rtl/pipe_stage.sv
// Full-throughput elastic register slice: accepts whenever empty or when
// the downstream side is taking the current word in the same cycle.
module pipe_stage #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         ready_o,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    input  logic         ready_i
);

    logic         valid_q;
    logic [W-1:0] data_q;

    assign ready_o = !valid_q || ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (ready_o) begin
            valid_q <= valid_i;
            if (valid_i) begin
                data_q <= data_i;
            end
        end
    end

endmodule

// File: rtl/pipe_accum.sv
// Frame accumulator: STAGES elastic slices feed a saturating adder that
// closes a frame on in_last or after ACC_BEATS beats and holds the result.
module pipe_accum
    import pipe_accum_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int RES_W     = DEF_RES_W,
    parameter int STAGES    = DEF_STAGES,
    parameter int ACC_BEATS = DEF_ACC_BEATS
) (
    input  logic        clk,
    input  logic        rst_n,
    pipe_accum_if.slave bus
);

    localparam int CNT_W = $clog2(ACC_BEATS + 1);
    localparam int PW    = DATA_W + 1;

    acc_state_e       state_q;
    logic [RES_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sat_q;
    logic             run_q;

    logic             acc_ready;
    logic             head_valid;
    logic [PW-1:0]    head_data;

    // Each slice owns its own nets so the ready chain stays a plain
    // combinational path rather than a self-referencing vector.
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic          vld_in, rdy_in, vld, rdy;
        logic [PW-1:0] dat_in, dat;

        if (i == 0) begin : g_first
            assign vld_in = bus.in_valid & run_q;
            assign dat_in = {bus.in_last, bus.in_data};
        end else begin : g_mid
            assign vld_in = g_stage[i-1].vld;
            assign dat_in = g_stage[i-1].dat;
        end

        if (i == STAGES - 1) begin : g_tail
            assign rdy_in = acc_ready;
        end else begin : g_body
            assign rdy_in = g_stage[i+1].rdy;
        end

        pipe_stage #(.W(PW)) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .valid_i (vld_in),
            .data_i  (dat_in),
            .ready_o (rdy),
            .valid_o (vld),
            .data_o  (dat),
            .ready_i (rdy_in)
        );
    end

    assign head_valid   = g_stage[STAGES-1].vld;
    assign head_data    = g_stage[STAGES-1].dat;
    assign bus.in_ready = g_stage[0].rdy & run_q;
    assign acc_ready    = (state_q != ST_HOLD);

    logic             absorb;
    logic             beat_last;
    logic [RES_W-1:0] beat_ext;
    logic [RES_W:0]   sum_d;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        absorb    = head_valid && acc_ready;
        beat_last = head_data[DATA_W];
        beat_ext  = RES_W'(head_data[DATA_W-1:0]);
        sum_d     = {1'b0, acc_q} + {1'b0, beat_ext};
        cnt_inc   = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            run_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (absorb) begin
                        acc_q   <= beat_ext;
                        cnt_q   <= CNT_W'(1);
                        sat_q   <= 1'b0;
                        state_q <= (beat_last || ACC_BEATS == 1) ? ST_HOLD : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (absorb) begin
                        if (sum_d[RES_W]) begin
                            acc_q <= '1;
                            sat_q <= 1'b1;
                        end else begin
                            acc_q <= sum_d[RES_W-1:0];
                        end
                        cnt_q <= cnt_inc;
                        if (beat_last || cnt_inc == CNT_W'(ACC_BEATS)) begin
                            state_q <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.result_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.result       = acc_q;
    assign bus.result_count = cnt_q;
    assign bus.result_sat   = sat_q;
    assign bus.result_valid = (state_q == ST_HOLD);

endmodule

// File: tb/tb_pipe_accum.sv
// Directed bench for pipe_accum: two instances (RES_W=16 and RES_W=9) see
// identical stimulus; a frame-sum model fills per-instance scoreboards.
module tb_pipe_accum;

    typedef struct {
        int res;
        int cnt;
        bit sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_accum_if #(.DATA_W(8), .RES_W(16), .CNT_W(3)) ifa ();
    pipe_accum_if #(.DATA_W(8), .RES_W(9),  .CNT_W(3)) ifb ();

    pipe_accum #(.DATA_W(8), .RES_W(16), .STAGES(2), .ACC_BEATS(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa)
    );
    pipe_accum #(.DATA_W(8), .RES_W(9), .STAGES(2), .ACC_BEATS(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb)
    );

    int   tests_run = 0;
    int   tests_failed = 0;
    int   cyc = 0;
    int   first_acc = -1;
    int   res_cyc = -1;
    int   m_sum[2];
    int   m_cnt[2];
    exp_t qa[$];
    exp_t qb[$];

    int   obs_valid_a, obs_res_a, obs_in_ready_a;

    task automatic chk(input string tag, input int obs, input int exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sum[0] = 0; m_sum[1] = 0;
        m_cnt[0] = 0; m_cnt[1] = 0;
        qa.delete();
        qb.delete();
    endtask

    task automatic model_beat(input int w, input int d, input bit l);
        exp_t e;
        int   maxv;
        maxv = (w == 0) ? 65535 : 511;
        m_sum[w] += d;
        m_cnt[w]++;
        if (l || m_cnt[w] == 4) begin
            e.sat = (m_sum[w] > maxv);
            e.res = e.sat ? maxv : m_sum[w];
            e.cnt = m_cnt[w];
            if (w == 0) qa.push_back(e);
            else        qb.push_back(e);
            m_sum[w] = 0;
            m_cnt[w] = 0;
        end
    endtask

    task automatic check_a();
        exp_t e;
        chk("a_result_expected", int'(qa.size() > 0), 1);
        if (qa.size() > 0) begin
            e = qa.pop_front();
            if (res_cyc < 0) res_cyc = cyc;
            chk("a_result", int'(ifa.result), e.res);
            chk("a_count", int'(ifa.result_count), e.cnt);
            chk("a_sat", int'(ifa.result_sat), int'(e.sat));
        end
    endtask

    task automatic check_b();
        exp_t e;
        chk("b_result_expected", int'(qb.size() > 0), 1);
        if (qb.size() > 0) begin
            e = qb.pop_front();
            chk("b_result", int'(ifb.result), e.res);
            chk("b_count", int'(ifb.result_count), e.cnt);
            chk("b_sat", int'(ifb.result_sat), int'(e.sat));
        end
    endtask

    // Called at posedge+1; samples at the negedge, returns at the next posedge+1.
    task automatic cycle(output bit acc);
        @(negedge clk);
        cyc++;
        acc = ifa.in_valid && ifa.in_ready;
        if (acc) begin
            if (first_acc < 0) first_acc = cyc;
            model_beat(0, int'(ifa.in_data), ifa.in_last);
        end
        if (ifb.in_valid && ifb.in_ready) model_beat(1, int'(ifb.in_data), ifb.in_last);
        obs_valid_a    = int'(ifa.result_valid);
        obs_res_a      = int'(ifa.result);
        obs_in_ready_a = int'(ifa.in_ready);
        if (ifa.result_valid && ifa.result_ready) check_a();
        if (ifb.result_valid && ifb.result_ready) check_b();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int d, input bit l);
        ifa.in_valid = v; ifa.in_data = 8'(d); ifa.in_last = l;
        ifb.in_valid = v; ifb.in_data = 8'(d); ifb.in_last = l;
    endtask

    task automatic set_rready(input bit r);
        ifa.result_ready = r;
        ifb.result_ready = r;
    endtask

    task automatic send(input int d, input bit l);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        drive(1'b1, d, l);
        while (!acc && n < 100) begin
            cycle(acc);
            n++;
        end
        chk("send_accepted", int'(acc), 1);
    endtask

    task automatic drain();
        bit acc;
        int n;
        n = 0;
        drive(1'b0, 8'hA5, 1'b1);
        while ((qa.size() != 0 || qb.size() != 0) && n < 60) begin
            cycle(acc);
            n++;
        end
        chk("drain_pending", qa.size() + qb.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, int'(ifa.in_ready), 0);
        chk({tag, "_result_valid"}, int'(ifa.result_valid), 0);
        chk({tag, "_result"}, int'(ifa.result), 0);
        chk({tag, "_count"}, int'(ifa.result_count), 0);
        chk({tag, "_sat"}, int'(ifa.result_sat), 0);
        chk({tag, "_b_result_valid"}, int'(ifb.result_valid), 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("in_ready_after_release", int'(ifa.in_ready), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit acc;
        int hb[8] = '{10, 20, 30, 40, 50, 60, 70, 80};
        int idx;
        int n;

        drive(1'b0, 0, 1'b0);
        set_rready(1'b1);
        model_reset();
        #3;
        chk_reset_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        release_reset();

        // Four back-to-back beats; result latency measured from first acceptance.
        first_acc = -1;
        res_cyc = -1;
        send(1, 1'b0); send(2, 1'b0); send(3, 1'b0); send(4, 1'b0);
        drain();
        chk("latency_first_result", res_cyc - first_acc, 6);
        @(negedge clk);
        chk("result_valid_one_cycle", int'(ifa.result_valid), 0);
        @(posedge clk);
        #1;

        // Early close on in_last, then a full frame of ones.
        send(5, 1'b0); send(7, 1'b1);
        send(1, 1'b0); send(1, 1'b0); send(1, 1'b0); send(1, 1'b0);
        drain();

        // Saturation on the narrow instance, plain sum on the wide one.
        send(255, 1'b0); send(255, 1'b0); send(255, 1'b0); send(255, 1'b0);
        drain();

        // Result held while downstream stalls; input backs up after two beats.
        set_rready(1'b0);
        send(1, 1'b0); send(2, 1'b0); send(3, 1'b0); send(4, 1'b0);
        drive(1'b0, 0, 1'b0);
        n = 0;
        obs_valid_a = 0;
        while (obs_valid_a == 0 && n < 20) begin
            cycle(acc);
            n++;
        end
        chk("hold_reached", obs_valid_a, 1);
        idx = 0;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, hb[idx], 1'b0);
            cycle(acc);
            if (acc) idx++;
            chk("hold_result_stable", obs_res_a, 10);
        end
        chk("hold_beats_accepted", idx, 2);
        chk("hold_in_ready_low", obs_in_ready_a, 0);
        chk("hold_result_valid", obs_valid_a, 1);
        set_rready(1'b1);
        while (idx < 8) begin
            send(hb[idx], 1'b0);
            idx++;
        end
        drain();

        // Reset in the middle of a frame discards the partial sum.
        send(1, 1'b0); send(2, 1'b0);
        drive(1'b0, 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        model_reset();
        @(posedge clk);
        #1;
        release_reset();
        send(2, 1'b0); send(3, 1'b0); send(4, 1'b0); send(5, 1'b0);
        drain();

        // Single zero beat closing its own frame.
        send(0, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipe_accum.md
PIPE_ACCUM -- requirements
Module: pipe_accum

Interface
REQ-001 Parameter DATA_W, default 8, input beat width; SHALL be >= 1.
REQ-002 Parameter RES_W, default 16, result width; SHALL be >= DATA_W.
REQ-003 Parameter STAGES, default 2, number of elastic register stages between input and accumulator; SHALL be >= 1.
REQ-004 Parameter ACC_BEATS, default 4, maximum beats per result frame; SHALL be >= 1.
REQ-005 Localparam CNT_W = $clog2(ACC_BEATS+1).
REQ-006 clk  input  1  single clock, all state rising-edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 in_data  input  DATA_W  beat payload, unsigned.
REQ-009 in_valid  input  1  beat offered.
REQ-010 in_last  input  1  beat closes the frame early.
REQ-011 in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-012 result  output  RES_W  frame sum.
REQ-013 result_count  output  CNT_W  beats in the frame.
REQ-014 result_sat  output  1  sum saturated.
REQ-015 result_valid  output  1  result presented.
REQ-016 result_ready  input  1  result consumed when result_valid && result_ready.

Function
REQ-017 Each stage SHALL be a full-throughput register slice: stage ready = !stage_valid || downstream ready; data, last and valid captured on stage handshake.
REQ-018 An accepted beat SHALL reach the accumulator input exactly STAGES cycles after acceptance when no stall occurs.
REQ-019 Accumulator FSM states SHALL be IDLE, ACCUM, HOLD.
REQ-020 IDLE: accumulator ready = 1; on beat, acc = beat, cnt = 1, go ACCUM, or HOLD if beat is last or ACC_BEATS == 1.
REQ-021 ACCUM: accumulator ready = 1; on beat, acc += beat, cnt += 1; go HOLD when the beat has last set or cnt reaches ACC_BEATS.
REQ-022 HOLD: accumulator ready = 0; result_valid = 1; result, result_count, result_sat SHALL stay stable until handshake; on handshake go IDLE (one-cycle bubble accepted).
REQ-023 Addition SHALL be RES_W+1 bits internally; on overflow acc SHALL clamp to all-ones and result_sat SHALL set and remain set for the frame.
REQ-024 result_valid SHALL rise the cycle after the closing beat is absorbed.
REQ-025 Backpressure in HOLD SHALL propagate stage by stage; in_ready SHALL fall only once all STAGES slices hold data; no beat SHALL be dropped or duplicated.
REQ-026 in_last on a beat that also reaches ACC_BEATS SHALL close one frame only.
REQ-027 in_data and in_last SHALL be ignored when in_valid = 0.

Reset
REQ-028 rst_n low SHALL asynchronously clear all stage valids, acc, cnt, result_sat, FSM to IDLE; outputs result = 0, result_count = 0, result_sat = 0, result_valid = 0, in_ready = 0 while rst_n low.
REQ-029 Reset mid-frame SHALL discard the partial frame; the first frame after release SHALL sum from zero.
REQ-030 in_ready SHALL assert the first cycle after rst_n deasserts.

Structure
REQ-031 Shared package pipe_accum_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-032 One sub-module pipe_stage (parametrised register slice, payload width DATA_W+1), instanced STAGES times via generate.
REQ-033 Accumulator and FSM SHALL live in pipe_accum.

Verification (DATA_W=8, STAGES=2, ACC_BEATS=4 unless stated)
REQ-034 Beats 1,2,3,4 back-to-back, result_ready=1 -> result=10, count=4, sat=0, result_valid high 6 cycles after first acceptance, for one cycle.
REQ-035 Beats 5,7 with in_last on 7 -> result=12, count=2; next frame 1,1,1,1 -> result=4.
REQ-036 RES_W=9, beats 255,255,255,255 -> result=511, sat=1, count=4.
REQ-037 result_ready low 10 cycles during HOLD, 8 beats offered -> result stable, in_ready low after 2 further beats, second sum correct after release.
REQ-038 rst_n pulsed low after 2 of 4 beats -> all outputs 0 immediately; then 2,3,4,5 -> result=14.
REQ-039 Single beat 0 with in_last -> result=0, count=1, sat=0.
